smem_arb: RTL and testbench

SMEM_ARB -- requirements
Module: smem_arb

---
 rtl/smem_arb_pkg.sv | 16 +
 rtl/smem_bitseq.sv | 23 ++
 rtl/smem_arb.sv | 164 ++++++++++++++++
 tb/tb_smem_arb.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/smem_arb_pkg.sv
// Shared constants and FSM state type for the bit-serial memory arbiter.
package smem_arb_pkg;

  localparam int unsigned WORD_BITS = 12;
  localparam int unsigned ADDR_W    = 7;
  localparam logic [3:0]  BA_IDLE   = 4'd12;

  typedef enum logic [2:0] {
    IDLE,
    RBIT,
    WHI,
    WLO,
    DONE
  } state_t;

endpackage

// File: rtl/smem_bitseq.sv
// Bit counter for one serial word access, flagging the final bit position.
module smem_bitseq #(
  parameter logic [3:0] LAST_BIT = 4'd11
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] cnt,
  output logic       last
);

  always_ff @(posedge sysclk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign last = (cnt == LAST_BIT);

endmodule

// File: rtl/smem_arb.sv
// Two-requester arbiter driving a bit-serial word memory, LSB first.
module smem_arb
  import smem_arb_pkg::*;
#(
  parameter int unsigned WORD_BITS = smem_arb_pkg::WORD_BITS,
  parameter int unsigned ADDR_W    = smem_arb_pkg::ADDR_W
) (
  input  logic                 sysclk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [ADDR_W-1:0]    addr0,
  input  logic [ADDR_W-1:0]    addr1,
  input  logic [WORD_BITS-1:0] wdata0,
  input  logic [WORD_BITS-1:0] wdata1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [WORD_BITS-1:0] rdata,
  output logic                 busy,
  output logic [ADDR_W-1:0]    ma,
  output logic [3:0]           ba,
  output logic                 mb,
  output logic                 write,
  input  logic                 membus
);

  state_t state_q, state_d;

  logic                 sel_q, sel_d;
  logic                 we_q, we_d;
  logic                 last_q, last_d;
  logic [WORD_BITS-1:0] wdata_q, wdata_d;
  logic [WORD_BITS-1:0] rdata_d;
  logic [ADDR_W-1:0]    ma_d;
  logic [3:0]           ba_d;
  logic                 mb_d, write_d, ack0_d, ack1_d, busy_d;

  logic [3:0] cnt, cnt_nxt;
  logic       cnt_clr, cnt_inc, cnt_last;
  logic       win;

  smem_bitseq #(
    .LAST_BIT(4'(WORD_BITS - 1))
  ) u_bitseq (
    .sysclk(sysclk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (cnt),
    .last  (cnt_last)
  );

  assign cnt_nxt = cnt + 4'd1;

  // With both requesting, the one not served last wins; otherwise whoever asks.
  assign win = (req0 && req1) ? ~last_q : req1;

  // Outputs are computed for the state being entered so they come out registered.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    we_d    = we_q;
    last_d  = last_q;
    wdata_d = wdata_q;
    rdata_d = rdata;
    ma_d    = ma;
    ba_d    = BA_IDLE;
    mb_d    = 1'b0;
    write_d = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          sel_d   = win;
          last_d  = win;
          we_d    = win ? we1 : we0;
          ma_d    = win ? addr1 : addr0;
          wdata_d = win ? wdata1 : wdata0;
          cnt_clr = 1'b1;
          ba_d    = 4'd0;
          if (we_d) begin
            state_d = WHI;
            mb_d    = wdata_d[0];
            write_d = 1'b1;
          end else begin
            state_d = RBIT;
          end
        end
      end
      RBIT: begin
        rdata_d[cnt] = membus;
        if (cnt_last) begin
          state_d = DONE;
        end else begin
          cnt_inc = 1'b1;
          ba_d    = cnt_nxt;
        end
      end
      WHI: begin
        state_d = WLO;
        ba_d    = cnt;
        mb_d    = mb;
      end
      WLO: begin
        if (cnt_last) begin
          state_d = DONE;
        end else begin
          state_d = WHI;
          cnt_inc = 1'b1;
          ba_d    = cnt_nxt;
          mb_d    = wdata_q[cnt_nxt];
          write_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ack0_d = (state_d == DONE) && !sel_d;
    ack1_d = (state_d == DONE) && sel_d;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      we_q    <= 1'b0;
      last_q  <= 1'b1;
      wdata_q <= '0;
      rdata   <= '0;
      ma      <= '0;
      ba      <= BA_IDLE;
      mb      <= 1'b0;
      write   <= 1'b0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      last_q  <= last_d;
      wdata_q <= wdata_d;
      rdata   <= rdata_d;
      ma      <= ma_d;
      ba      <= ba_d;
      mb      <= mb_d;
      write   <= write_d;
      ack0    <= ack0_d;
      ack1    <= ack1_d;
      busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_smem_arb.sv
// Self-checking bench for smem_arb: bit-serial memory model, word-level reference model, directed tests.
module tb_smem_arb;

  localparam int WB = 12;
  localparam int AW = 7;

  logic          sysclk = 1'b0;
  logic          reset  = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [WB-1:0] wdata0 = '0, wdata1 = '0;
  logic          ack0, ack1, busy, mb, write, membus;
  logic [WB-1:0] rdata;
  logic [AW-1:0] ma;
  logic [3:0]    ba;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  smem_arb #(.WORD_BITS(WB), .ADDR_W(AW)) dut (
    .sysclk(sysclk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .ma(ma), .ba(ba), .mb(mb), .write(write), .membus(membus)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0o expected %0o (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Bit-serial memory: address/data captured mid-cycle while write is high, committed on its fall.
  logic [WB-1:0] pmem [2**AW];
  logic [AW-1:0] cap_a;
  logic [3:0]    cap_b;
  logic          cap_d;
  logic          cap_valid = 1'b0;
  int            wfalls = 0;
  int            n_acks = 0;
  int            ba_q[$];

  always_comb membus = (ba < 4'd12) ? pmem[ma][ba] : 1'b0;

  always @(negedge sysclk) begin
    if (write === 1'b1) begin
      cap_a = ma; cap_b = ba; cap_d = mb; cap_valid = 1'b1;
      ba_q.push_back(int'(ba));
    end
    if (ack0 === 1'b1) n_acks++;
    if (ack1 === 1'b1) n_acks++;
  end

  always @(negedge write) begin
    if (cap_valid) begin
      pmem[cap_a][cap_b] = cap_d;
      wfalls++;
    end
  end

  // Reference model: an access is a numbered sequence of cycles 1..len after the granting edge.
  logic [WB-1:0] ref_mem [2**AW];
  int            m_k = 0, m_len = 0;
  logic          m_sel = 1'b0, m_we = 1'b0, m_last = 1'b1;
  logic [AW-1:0] m_addr = '0, m_ma = '0;
  logic [WB-1:0] m_wdata = '0, m_rdata = '0;

  always @(posedge sysclk) begin
    if (m_k > 0 && m_we && (m_k % 2 == 1) && m_k < m_len)
      ref_mem[m_addr][(m_k-1)/2] = m_wdata[(m_k-1)/2];
    if (reset) begin
      m_k = 0; m_last = 1'b1; m_ma = '0; m_rdata = '0;
    end else if (m_k > 0) begin
      if (!m_we && m_k == m_len - 1) m_rdata = ref_mem[m_addr];
      m_k++;
      if (m_k > m_len) m_k = 0;
    end else if (req0 || req1) begin
      if (req0 && req1) m_sel = (m_last == 1'b1) ? 1'b0 : 1'b1;
      else              m_sel = req1;
      m_last  = m_sel;
      m_we    = m_sel ? we1 : we0;
      m_addr  = m_sel ? addr1 : addr0;
      m_wdata = m_sel ? wdata1 : wdata0;
      m_ma    = m_addr;
      m_len   = m_we ? 2*WB + 1 : WB + 1;
      m_k     = 1;
    end
  end

  logic chk_on = 1'b0;

  always @(negedge sysclk) begin : cmp
    logic       e_busy, e_ack0, e_ack1, e_wr, e_mb;
    logic [3:0] e_ba;
    if (chk_on) begin
      e_busy = (m_k != 0);
      e_ack0 = (m_k != 0) && (m_k == m_len) && !m_sel;
      e_ack1 = (m_k != 0) && (m_k == m_len) && m_sel;
      if (m_k == 0 || m_k == m_len) e_ba = 4'd12;
      else e_ba = m_we ? 4'((m_k-1)/2) : 4'(m_k-1);
      e_wr = m_we && m_k > 0 && m_k < m_len && (m_k % 2 == 1);
      e_mb = (m_we && m_k > 0 && m_k < m_len) ? m_wdata[(m_k-1)/2] : 1'b0;
      chk("busy", busy, e_busy);
      chk("ack0", ack0, e_ack0);
      chk("ack1", ack1, e_ack1);
      chk("ba", ba, e_ba);
      chk("write", write, e_wr);
      chk("mb", mb, e_mb);
      chk("ma", ma, m_ma);
      if (!(m_k > 0 && !m_we && m_k < m_len)) chk("rdata", rdata, m_rdata);
    end
  end

  task automatic start(input int sel, input logic we, input logic [AW-1:0] a,
                       input logic [WB-1:0] d, output int c0);
    @(negedge sysclk);
    if (sel == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else          begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
    c0 = cyc + 1;
  endtask

  // Latency counts the ack cycle as cycle N after the sampling edge.
  task automatic wait_ack(input int sel, input int c0, output int lat, output logic [WB-1:0] rd);
    lat = -1;
    rd  = '0;
    for (int i = 0; i < 80; i++) begin
      @(negedge sysclk);
      if ((sel == 0 && ack0 === 1'b1) || (sel == 1 && ack1 === 1'b1)) begin
        lat = cyc - c0 + 1;
        rd  = rdata;
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL ack%0d_timeout: got none expected pulse within 80 cycles", sel);
    end
  endtask

  initial begin : timeout
    #400000;
    errors++;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : stim
    int            c0, lat, wf0, acks0, mm, gseq[4];
    logic [WB-1:0] rd, rseq[4];
    int            ng;

    for (int i = 0; i < 2**AW; i++) begin pmem[i] = '0; ref_mem[i] = '0; end
    pmem['o101] = 12'o1104; ref_mem['o101] = 12'o1104;
    pmem['o102] = 12'o3105; ref_mem['o102] = 12'o3105;

    repeat (3) @(negedge sysclk);
    chk("rst_ba", ba, 12);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ma", ma, 0);
    chk("rst_write", write, 0);
    chk("rst_acks", {ack0, ack1}, 0);
    chk_on = 1'b1;
    reset  = 1'b0;

    // Write from requester 0 then read back through requester 1.
    start(0, 1'b1, 7'o100, 12'o7300, c0);
    wait_ack(0, c0, lat, rd);
    req0 = 1'b0;
    chk("w100_latency", lat, 25);
    start(1, 1'b0, 7'o100, '0, c0);
    wait_ack(1, c0, lat, rd);
    req1 = 1'b0;
    chk("r100_latency", lat, 13);
    chk("r100_data", rd, 12'o7300);
    chk("model_mem100", ref_mem['o100], 12'o7300);

    // Both requesters held: grants alternate starting with requester 0.
    @(negedge sysclk); reset = 1'b1;
    @(negedge sysclk); reset = 1'b0;
    @(negedge sysclk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 7'o101;
    req1 = 1'b1; we1 = 1'b0; addr1 = 7'o102;
    ng = 0;
    for (int i = 0; i < 200 && ng < 4; i++) begin
      @(negedge sysclk);
      if (ack0 === 1'b1) begin gseq[ng] = 0; rseq[ng] = rdata; ng++; end
      else if (ack1 === 1'b1) begin gseq[ng] = 1; rseq[ng] = rdata; ng++; end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("alt_count", ng, 4);
    for (int i = 0; i < ng; i++) begin
      chk("alt_grant", gseq[i], i % 2);
      chk("alt_rdata", rseq[i], (i % 2 == 0) ? 12'o1104 : 12'o3105);
    end

    // Write 0o1234 to 0o105: twelve strobes, ba 0..11 in order.
    ba_q.delete();
    wf0 = wfalls;
    start(0, 1'b1, 7'o105, 12'o1234, c0);
    wait_ack(0, c0, lat, rd);
    req0 = 1'b0;
    chk("w105_ba_done", ba, 12);
    chk("w105_latency", lat, 25);
    chk("w105_falls", wfalls - wf0, 12);
    chk("w105_ba_len", ba_q.size(), 12);
    for (int i = 0; i < ba_q.size() && i < 12; i++) chk("w105_ba_seq", ba_q[i], i);
    @(negedge sysclk);
    chk("w105_mem", pmem['o105], 12'o1234);
    chk("model_mem105", ref_mem['o105], 12'o1234);

    // Reset lands in WHI of bit 5 while writing 0o7777 over zero.
    acks0 = n_acks;
    start(0, 1'b1, 7'o110, 12'o7777, c0);
    for (int i = 0; i < 40 && cyc != c0 + 10; i++) @(negedge sysclk);
    chk("whi5_write", write, 1);
    chk("whi5_ba", ba, 5);
    reset = 1'b1;
    req0  = 1'b0;
    @(negedge sysclk);
    chk("rstw_ba", ba, 12);
    chk("rstw_write", write, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_mb", mb, 0);
    chk("rstw_ma", ma, 0);
    chk("rstw_rdata", rdata, 0);
    reset = 1'b0;
    repeat (30) @(negedge sysclk);
    chk("rstw_no_ack", n_acks - acks0, 0);
    chk("rstw_mem", pmem['o110], 12'o0077);
    chk("model_mem110", ref_mem['o110], 12'o0077);

    // Request dropped two cycles into a read still completes.
    start(1, 1'b0, 7'o102, '0, c0);
    repeat (2) @(negedge sysclk);
    req1 = 1'b0;
    wait_ack(1, c0, lat, rd);
    chk("drop_latency", lat, 13);
    chk("drop_rdata", rd, 12'o3105);
    @(negedge sysclk);
    chk("drop_idle", busy, 0);

    mm = 0;
    for (int i = 0; i < 2**AW; i++) if (pmem[i] !== ref_mem[i]) mm++;
    chk("mem_image", mm, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
